// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over req/ack and steps phases 1..5.
// Optional PC_ALIGN_CHECK_EN: a misaligned jump target halts the sequencer and sets trap_misalign.
module inst_seq_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic [7:0]  instcycle_cnt_val,
  input  logic        pc_jmp,
  input  logic [63:0] pc_jmpaddr,
  output logic        inst_commit,
  output logic [63:0] instret,
  output logic        trap_misalign
);

  typedef enum logic [7:0] {
    PH_IDLE   = 8'd0,
    PH_FETCH  = 8'd1,
    PH_DECODE = 8'd2,
    PH_READ   = 8'd3,
    PH_EXEC   = 8'd4,
    PH_COMMIT = 8'd5,
    PH_HALT   = 8'hFF
  } phase_t;

  phase_t      cnt_q, cnt_d;
  logic [63:0] pc_q, pc_d;
  logic        if_req_q, if_req_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic        trap_d;
  logic        misalign_jmp;

`ifdef PC_ALIGN_CHECK_EN
  logic        trap_q;
  assign misalign_jmp = pc_jmp && (pc_jmpaddr[1:0] != 2'b00);
`else
  assign misalign_jmp = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    if_req_d  = if_req_q;
    inst_d    = inst_q;
    instret_d = instret_q;
`ifdef PC_ALIGN_CHECK_EN
    trap_d    = trap_q;
`else
    trap_d    = 1'b0;
`endif
    case (cnt_q)
      PH_IDLE: begin
        cnt_d    = PH_FETCH;
        if_req_d = 1'b1;
      end
      PH_FETCH: begin
        // Address stays on if_addr until the handshake completes; no timeout.
        if (if_req_q && if_ack) begin
          inst_d   = if_rdata;
          if_req_d = 1'b0;
          cnt_d    = PH_DECODE;
        end
      end
      PH_DECODE: cnt_d = PH_READ;
      PH_READ:   cnt_d = PH_EXEC;
      PH_EXEC:   cnt_d = PH_COMMIT;
      PH_COMMIT: begin
        if (misalign_jmp) begin
          trap_d   = 1'b1;
          cnt_d    = PH_HALT;
          if_req_d = 1'b0;
        end else begin
          pc_d      = pc_jmp ? pc_jmpaddr : pc_q + 64'd4;
          instret_d = instret_q + 64'd1;
          cnt_d     = PH_FETCH;
          if_req_d  = 1'b1;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      PH_HALT: cnt_d = PH_HALT;
`endif
      default: begin
        // Unreachable counter value: fall back to IDLE and restart the fetch.
        cnt_d    = PH_IDLE;
        if_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= PH_IDLE;
      pc_q      <= PC_RESET;
      if_req_q  <= 1'b0;
      inst_q    <= 32'd0;
      instret_q <= 64'd0;
    end else begin
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      if_req_q  <= if_req_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign trap_misalign = trap_q;
`else
  assign trap_misalign = trap_d;
`endif

  assign if_req            = if_req_q;
  assign if_addr           = pc_q;
  assign pc                = pc_q;
  assign inst              = inst_q;
  assign instret           = instret_q;
  assign instcycle_cnt_val = cnt_q;
  assign inst_commit       = (cnt_q == PH_COMMIT);

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl: fetch responder, EX jump driver and commit scoreboard.
module tb_inst_seq_ctrl;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [7:0]  cnt;
  logic        pc_jmp;
  logic [63:0] pc_jmpaddr;
  logic        inst_commit;
  logic [63:0] instret;
  logic        trap_misalign;

  inst_seq_ctrl #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .inst(inst), .pc(pc), .instcycle_cnt_val(cnt),
    .pc_jmp(pc_jmp), .pc_jmpaddr(pc_jmpaddr),
    .inst_commit(inst_commit), .instret(instret), .trap_misalign(trap_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] pc_m;
  logic [63:0] instret_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_if_req", {63'd0, if_req}, 64'd1 - 64'd1);
    check("rst_pc", pc, PC_RESET);
    check("rst_cnt", {56'd0, cnt}, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_trap", {63'd0, trap_misalign}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if_ack = 1'b0;
    pc_m = PC_RESET;
    instret_m = 64'd0;
    sb.delete();
    #1;
    check("rel_cnt", {56'd0, cnt}, 64'd0);
    check("rel_inst", {32'd0, inst}, 64'd0);
    check("rel_commit", {63'd0, inst_commit}, 64'd0);
  endtask

  // One instruction: fetch with given ack delay, optional noise in phase 3, optional jump at commit.
  task automatic run_inst(input int delay, input logic [31:0] rdata, input bit jmp,
                          input logic [63:0] jaddr, input bit noise);
    int   n;
    exp_t e;
    exp_t g;
    bit   misal;
    n = 0;
    while (if_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (if_req !== 1'b1) begin
      check("fetch_timeout", {63'd0, if_req}, 64'd1);
      return;
    end
    check("fetch_addr", if_addr, pc_m);
    check("fetch_cnt", {56'd0, cnt}, 64'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_cnt", {56'd0, cnt}, 64'd1);
      check("hold_addr", if_addr, pc_m);
      check("hold_req", {63'd0, if_req}, 64'd1);
    end
    if_ack = 1'b1;
    if_rdata = rdata;
    e.pc = pc_m;
    e.inst = rdata;
    sb.push_back(e);
    @(negedge clk);
    if_ack = 1'b0;
    if_rdata = 32'hDEAD_BEEF;
    check("cnt2", {56'd0, cnt}, 64'd2);
    check("inst_latch", {32'd0, inst}, {32'd0, rdata});
    check("req_drop", {63'd0, if_req}, 64'd0);
    @(negedge clk);
    check("cnt3", {56'd0, cnt}, 64'd3);
    if (noise) begin
      pc_jmp = 1'b1;
      pc_jmpaddr = 64'h0000_0000_1234_5670;
      if_ack = 1'b1;
      if_rdata = ~rdata;
    end
    @(negedge clk);
    check("cnt4", {56'd0, cnt}, 64'd4);
    pc_jmp = jmp;
    pc_jmpaddr = jaddr;
    if_ack = 1'b0;
    @(negedge clk);
    check("cnt5", {56'd0, cnt}, 64'd5);
    check("commit", {63'd0, inst_commit}, 64'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    g = sb.pop_front();
    check("commit_pc", pc, g.pc);
    check("commit_inst", {32'd0, inst}, {32'd0, g.inst});
`ifdef PC_ALIGN_CHECK_EN
    misal = jmp && (jaddr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    @(negedge clk);
    pc_jmp = 1'b0;
    if (misal) begin
      check("trap_set", {63'd0, trap_misalign}, 64'd1);
      check("halt_cnt", {56'd0, cnt}, 64'hFF);
      check("halt_pc", pc, g.pc);
      check("halt_instret", instret, instret_m);
      repeat (5) @(negedge clk);
      check("halt_req", {63'd0, if_req}, 64'd0);
      check("halt_hold", {56'd0, cnt}, 64'hFF);
      check("trap_sticky", {63'd0, trap_misalign}, 64'd1);
    end else begin
      pc_m = jmp ? jaddr : pc_m + 64'd4;
      instret_m = instret_m + 64'd1;
      check("next_cnt", {56'd0, cnt}, 64'd1);
      check("next_pc", pc, pc_m);
      check("instret", instret, instret_m);
      check("next_req", {63'd0, if_req}, 64'd1);
      check("commit_low", {63'd0, inst_commit}, 64'd0);
      check("trap_clear", {63'd0, trap_misalign}, 64'd0);
    end
    $display("inst pc=%h inst=%h jmp=%0d delay=%0d instret=%0d", g.pc, g.inst, jmp, delay, instret);
  endtask

  initial begin
    rst = 1'b1;
    if_ack = 1'b0;
    if_rdata = 32'd0;
    pc_jmp = 1'b0;
    pc_jmpaddr = 64'd0;
    repeat (2) @(negedge clk);
    do_reset();

    run_inst(0, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
    run_inst(3, 32'h00A0_0093, 1'b0, 64'd0, 1'b0);
    run_inst(0, 32'h1111_2222, 1'b1, 64'h0000_0000_8000_0100, 1'b0);
    run_inst(1, 32'h3333_4444, 1'b0, 64'd0, 1'b1);
    run_inst(2, 32'h5555_6666, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    run_inst(0, 32'h7777_8888, 1'b0, 64'd0, 1'b0);
    run_inst(0, 32'h9999_AAAA, 1'b1, 64'h0000_0000_8000_0200, 1'b1);

    // Reset while a fetch is outstanding, with an ack arriving alongside it.
    while (if_req !== 1'b1) @(negedge clk);
    @(negedge clk);
    if_ack = 1'b1;
    if_rdata = 32'hCAFE_F00D;
    do_reset();
    run_inst(0, 32'hBBBB_CCCC, 1'b0, 64'd0, 1'b0);

    run_inst(0, 32'hDDDD_EEEE, 1'b1, 64'h0000_0000_8000_0102, 1'b0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_inst(int'($urandom_range(0, 4)), $urandom, 1'(k % 2),
               {32'h0, $urandom & 32'hFFFF_FFFC}, 1'(k % 3 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
